// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the 4-bit CPU run controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HALT = 2'd1,
    RUN  = 2'd2,
    STEP = 2'd3
  } state_t;

  localparam logic [3:0]  HOLD_OP   = 4'hF;
  localparam int unsigned RAM_DEPTH = 16;

endpackage

// File: rtl/instr_ram.sv
// Instruction store: one synchronous write port, asynchronous read port.
module instr_ram
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_run_controller.sv
// Load/halt/run/step sequencer for the 4-bit core, with PC breakpoint.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              cmd_run,
  input  logic              cmd_halt,
  input  logic              cmd_step,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] cpu_address,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_n_reset,
  output logic [1:0]        state_o,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  instr_count
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic [CNT_W-1:0]  cnt;
  logic              bp_mask;
  logic              bp_hit_r;
  logic              brk;
  logic              exec;
  logic              clr_cnt;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  instr_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ptr),
    .wdata (load_data),
    .raddr (cpu_address),
    .rdata (ram_rdata)
  );

  // Breakpoint is masked on the first cycle after leaving HALT so a resume
  // from the break PC executes that instruction instead of re-breaking.
  always_comb begin
    brk    = (state == RUN) && bp_en && (cpu_address == bp_addr) && !bp_mask;
    exec   = ((state == RUN) && !brk) || (state == STEP);
    ram_we = (state == LOAD) && load_valid && !load_start && !reset;
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    clr_cnt  = 1'b0;
    if (load_start) begin
      state_nx = LOAD;
      ptr_nx   = '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (load_valid) begin
            ptr_nx = ptr + 1'b1;
            if (ptr == '1) begin
              state_nx = HALT;
              clr_cnt  = 1'b1;
            end
          end
        end
        HALT: begin
          if (cmd_run)       state_nx = RUN;
          else if (cmd_step) state_nx = STEP;
        end
        RUN: begin
          if (cmd_halt || brk) state_nx = HALT;
        end
        STEP: state_nx = HALT;
      endcase
    end
  end

  always_comb begin
    cpu_instr = '0;
    unique case (state)
      LOAD: cpu_instr = '0;
      HALT: cpu_instr = {HOLD_OP, cpu_address};
      RUN:  cpu_instr = brk ? {HOLD_OP, cpu_address} : ram_rdata;
      STEP: cpu_instr = ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      ptr      <= '0;
      cnt      <= '0;
      bp_mask  <= 1'b0;
      bp_hit_r <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      bp_hit_r <= brk;
      bp_mask  <= (state == HALT) && (state_nx != HALT);
      if (clr_cnt)                  cnt <= '0;
      else if (exec && (cnt != '1)) cnt <= cnt + 1'b1;
    end
  end

  assign cpu_n_reset = (state != LOAD);
  assign load_ready  = (state == LOAD) && !reset;
  assign state_o     = state;
  assign bp_hit      = bp_hit_r;
  assign instr_count = cnt;

endmodule
